// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store memory controller.
// Holds the FSM state encoding, the decoded operation type and the byte-merge helper.
package lsu_pkg;

  localparam int LSU_ADDR_W = 14;
  localparam int LSU_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

  // Encoding is {we, byte} so the request fields cast straight onto it.
  typedef enum logic [1:0] {
    LD_W = 2'b00,
    LD_B = 2'b01,
    ST_W = 2'b10,
    ST_B = 2'b11
  } lsu_op_e;

  function automatic lsu_op_e decode_op(input logic we, input logic is_byte);
    return lsu_op_e'({we, is_byte});
  endfunction

  // Byte at A sits in the upper half of the word at A; the lower half (byte A-1) is kept.
  function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic [7:0] b);
    return {b, word[7:0]};
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request per handshake, byte stores via read-modify-write,
// held response channel. Optional misaligned-word check enabled by LSU_ALIGN_CHK_EN.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready, and rsp_valid,
  // rsp_rdata and rsp_err hold steady until then.

  lsu_state_e state;
  lsu_state_e state_next;
  lsu_op_e    op_q;
  logic       misalign;

`ifdef LSU_ALIGN_CHK_EN
  logic err_q;
  // A word at A is {byte[A], byte[A-1]}, so a word address is aligned when A is odd.
  assign misalign = !req_byte && !req_addr[0];
  assign rsp_err  = err_q;
`else
  assign misalign = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_we    = ((state == ACCESS) && (op_q == ST_W)) || (state == RMW_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_next = RESP;
          end else if (decode_op(req_we, req_byte) == ST_B) begin
            state_next = RMW_RD;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS:  state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= LD_W;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
`ifdef LSU_ALIGN_CHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= decode_op(req_we, req_byte);
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            rsp_rdata <= '0;
`ifdef LSU_ALIGN_CHK_EN
            err_q     <= misalign;
`endif
          end
        end
        ACCESS: begin
          case (op_q)
            LD_W:    rsp_rdata <= mem_rdata;
            LD_B:    rsp_rdata <= {8'h00, mem_rdata[15:8]};
            default: rsp_rdata <= '0;
          endcase
        end
        // mem_wdata still carries the request data, so its low byte is the store byte.
        RMW_RD: mem_wdata <= merge_byte(mem_rdata, mem_wdata[7:0]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-array memory model and assertion checks.
// Build with LSU_ALIGN_CHK_EN defined to cover the misaligned-word error path.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              mem_clr;
  logic [ADDR_W-1:0] lo_addr;
  int                we_cnt;

  int                tests = 0;
  int                fails = 0;
  logic [DATA_W-1:0] exp_q [$];

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always_comb begin
    lo_addr   = mem_addr - 14'd1;
    mem_rdata = {mem[mem_addr], mem[lo_addr]};
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 8'h00;
      we_cnt <= 0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata[15:8];
      mem[lo_addr]  <= mem_wdata[7:0];
      we_cnt        <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the accept edge
  task automatic issue(input logic we, input logic b, input logic [13:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 16'(n < 20), 16'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic b, input logic [13:0] a,
                     input logic [15:0] d, input int exp_lat, input int exp_we, input logic exp_err);
    int k;
    int w0;
    logic [15:0] exp;
    w0 = we_cnt;
    issue(we, b, a, d);
    wait_rsp(k);
    check({tag, "_lat"}, 16'(k), 16'(exp_lat));
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, exp);
    check({tag, "_err"}, 16'(rsp_err), 16'(exp_err));
    retire();
    check({tag, "_rsp_drop"}, 16'(rsp_valid), 16'd0);
    check({tag, "_ready_back"}, 16'(req_ready), 16'd1);
    check({tag, "_we_pulses"}, 16'(we_cnt - w0), 16'(exp_we));
  endtask

  initial begin
    int k;
    int w0;
    rst       = 1'b1;
    mem_clr   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;

    check("rst_req_ready", 16'(req_ready), 16'd1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    check("rst_rsp_err", 16'(rsp_err), 16'd0);
    check("rst_mem_we", 16'(mem_we), 16'd0);
    check("rst_mem_addr", 16'(mem_addr), 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);

    // word store then word load
    exp_q.push_back(16'h0000);
    txn("st_w", 1'b1, 1'b0, 14'h0011, 16'hBEEF, 1, 1, 1'b0);
    check("st_w_hi", 16'(mem[14'h0011]), 16'h00BE);
    check("st_w_lo", 16'(mem[14'h0010]), 16'h00EF);
    exp_q.push_back(16'hBEEF);
    txn("ld_w", 1'b0, 1'b0, 14'h0011, 16'h0000, 1, 0, 1'b0);

    // byte store over BEEF, then word and byte loads
    exp_q.push_back(16'h0000);
    txn("st_b", 1'b1, 1'b1, 14'h0011, 16'h0042, 2, 1, 1'b0);
    check("st_b_hi", 16'(mem[14'h0011]), 16'h0042);
    check("st_b_lo", 16'(mem[14'h0010]), 16'h00EF);
    exp_q.push_back(16'h42EF);
    txn("ld_w2", 1'b0, 1'b0, 14'h0011, 16'h0000, 1, 0, 1'b0);
    exp_q.push_back(16'h0042);
    txn("ld_b", 1'b0, 1'b1, 14'h0011, 16'h0000, 1, 0, 1'b0);

    // response stall with a new request pending; retire and request collide
    issue(1'b0, 1'b0, 14'h0011, 16'h0000);
    wait_rsp(k);
    check("stall_lat", 16'(k), 16'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_byte  = 1'b1;
    req_addr  = 14'h0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 16'(rsp_valid), 16'd1);
      check("stall_rdata", rsp_rdata, 16'h42EF);
      check("stall_ready", 16'(req_ready), 16'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("collide_rsp_drop", 16'(rsp_valid), 16'd0);
    check("collide_req_wait", 16'(req_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("collide_accepted", 16'(req_ready), 16'd0);
    wait_rsp(k);
    check("collide_lat", 16'(k), 16'd1);
    check("collide_rdata", rsp_rdata, 16'h00EF);
    retire();

    // reset while in RMW_RD aborts the byte store
    w0 = we_cnt;
    issue(1'b1, 1'b1, 14'h0021, 16'h0077);
    check("abort_in_rmw_rd", 16'(dut.state), 16'(RMW_RD));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 16'(dut.state), 16'(IDLE));
    check("abort_req_ready", 16'(req_ready), 16'd1);
    check("abort_rsp_valid", 16'(rsp_valid), 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_mem_we", 16'(mem_we), 16'd0);
    end
    check("abort_we_cnt", 16'(we_cnt - w0), 16'd0);
    check("abort_mem_hi", 16'(mem[14'h0021]), 16'h0000);
    check("abort_mem_lo", 16'(mem[14'h0020]), 16'h0000);
    exp_q.push_back(16'h42EF);
    txn("ld_after_rst", 1'b0, 1'b0, 14'h0011, 16'h0000, 1, 0, 1'b0);

`ifdef LSU_ALIGN_CHK_EN
    exp_q.push_back(16'h0000);
    txn("misalign_st", 1'b1, 1'b0, 14'h0010, 16'h5555, 0, 0, 1'b1);
    check("misalign_hi", 16'(mem[14'h0010]), 16'h00EF);
    check("misalign_lo", 16'(mem[14'h000F]), 16'h0000);
    exp_q.push_back(16'h0000);
    txn("misalign_ld", 1'b0, 1'b0, 14'h0010, 16'h0000, 0, 0, 1'b1);
    exp_q.push_back(16'h0000);
    txn("even_byte_st", 1'b1, 1'b1, 14'h0030, 16'h00A5, 2, 1, 1'b0);
    check("even_byte_hi", 16'(mem[14'h0030]), 16'h00A5);
`else
    exp_q.push_back(16'h0000);
    txn("wrap_st", 1'b1, 1'b0, 14'h0000, 16'h1234, 1, 1, 1'b0);
    check("wrap_hi", 16'(mem[14'h0000]), 16'h0012);
    check("wrap_lo", 16'(mem[14'h3FFF]), 16'h0034);
    exp_q.push_back(16'h1234);
    txn("wrap_ld", 1'b0, 1'b0, 14'h0000, 16'h0000, 1, 0, 1'b0);
    exp_q.push_back(16'h0000);
    txn("wrap_st_b", 1'b1, 1'b1, 14'h0000, 16'h0099, 2, 1, 1'b0);
    check("wrap_b_hi", 16'(mem[14'h0000]), 16'h0099);
    check("wrap_b_lo", 16'(mem[14'h3FFF]), 16'h0034);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
